// File: rtl/bcd_7seg_pkg.sv
// Shared constants for the multiplexed BCD 7-segment display driver.
//
// Contents:
//   MIN_REFRESH_DIV   smallest legal number of clock cycles per digit slot
//   SEG_*_BIT         bit position of each segment in the 7-bit segment bus
//   SEG_0..SEG_9      active-low segment patterns, bus order {g,f,e,d,c,b,a}
//   SEG_BLANK         all segments off
package bcd_7seg_pkg;

  // One cycle of dead time plus at least one lit cycle per slot.
  localparam int MIN_REFRESH_DIV = 2;

  // Segment bit order on the bus: {g,f,e,d,c,b,a}.
  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  // Active-low patterns: a 0 bit lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to 7-segment decoder.
//
// Ports:
//   bcd  in   4-bit digit code; 0..9 decode to numerals, 10..15 decode blank
//   seg  out  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
  import bcd_7seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed 7-segment display driver.
//
// Accepts a packed BCD word (digit k in bits [4k+3:4k]) plus per-digit
// decimal-point requests, double-buffers them so the visible value only
// changes at frame boundaries, and scans one digit at a time onto a shared
// active-low segment bus. The first cycle of every digit slot is dead time
// (all anodes off) while the segment bus settles on the new digit.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 is never blanked; decimal points are still shown).
//
// Ports:
//   CLK_i    in   clock, rising edge
//   RST_N_i  in   asynchronous active-low reset
//   BCD_i    in   4*N_DIGITS BCD word
//   DP_i     in   N_DIGITS decimal-point requests, 1 = lit
//   LOAD_i   in   capture BCD_i/DP_i this cycle
//   SEG_o    out  segments {g,f,e,d,c,b,a}, active-low
//   DP_o     out  decimal point, active-low
//   AN_o     out  digit enables, active-low, at most one low
//   FRAME_o  out  one-cycle pulse at the start of each digit-0 slot
module bcd_7seg_scan
  import bcd_7seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
)
(
  input  logic                  CLK_i,
  input  logic                  RST_N_i,
  input  logic [4*N_DIGITS-1:0] BCD_i,
  input  logic [N_DIGITS-1:0]   DP_i,
  input  logic                  LOAD_i,
  output logic [6:0]            SEG_o,
  output logic                  DP_o,
  output logic [N_DIGITS-1:0]   AN_o,
  output logic                  FRAME_o
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  if (REFRESH_DIV < MIN_REFRESH_DIV) begin : g_bad_div
    $error("bcd_7seg_scan: REFRESH_DIV below minimum");
  end

  // run_reg is clear only between reset release and the first edge; that
  // edge enters the digit-0 slot without advancing the prescaler, so the
  // scan always restarts cleanly at digit 0.
  logic                  run_reg;
  logic [PW-1:0]         presc_reg, presc_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [4*N_DIGITS-1:0] disp_bcd_reg, disp_bcd_next;
  logic [N_DIGITS-1:0]   disp_dp_reg, disp_dp_next;
  logic [4*N_DIGITS-1:0] pend_bcd_reg, pend_bcd_next;
  logic [N_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
  logic                  pend_flag_reg, pend_flag_next;
  logic                  swap;

  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;
  logic [N_DIGITS-1:0]   an_reg, an_next;
  logic                  frame_reg;

  // Scan position and buffer update.
  always_comb begin
    presc_next     = presc_reg;
    idx_next       = idx_reg;
    disp_bcd_next  = disp_bcd_reg;
    disp_dp_next   = disp_dp_reg;
    pend_bcd_next  = pend_bcd_reg;
    pend_dp_next   = pend_dp_reg;
    pend_flag_next = pend_flag_reg;

    if (!run_reg) begin
      presc_next = '0;
      idx_next   = '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_next = '0;
      idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      presc_next = presc_reg + 1'b1;
    end

    // Entering a digit-0 slot is the only point where the visible value may change.
    swap = (presc_next == '0) && (idx_next == '0);

    if (swap) begin
      pend_flag_next = 1'b0;
      if (LOAD_i) begin
        // A load on the swap edge is newer than anything pending.
        disp_bcd_next = BCD_i;
        disp_dp_next  = DP_i;
      end else if (pend_flag_reg) begin
        disp_bcd_next = pend_bcd_reg;
        disp_dp_next  = pend_dp_reg;
      end
    end else if (LOAD_i) begin
      pend_bcd_next  = BCD_i;
      pend_dp_next   = DP_i;
      pend_flag_next = 1'b1;
    end
  end

  // Outputs are decoded from the next state so every output is a register
  // that already matches the slot it belongs to.
  logic [3:0]          digit_arr [N_DIGITS];
  logic [N_DIGITS-1:0] lz_blank;
  logic [3:0]          cur_digit;
  logic [6:0]          dec_seg;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign digit_arr[gi] = disp_bcd_next[4*gi +: 4];
    assign an_next[gi]   = !((presc_next != '0) && (idx_next == IW'(gi)));
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
    if (gi == 0) begin : g_lsd
      assign lz_blank[gi] = 1'b0;
    end else begin : g_upper
      assign lz_blank[gi] = (disp_bcd_next[4*N_DIGITS-1:4*gi] == '0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_digit = digit_arr[idx_next];

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    seg_next = lz_blank[idx_next] ? SEG_BLANK : dec_seg;
    dp_next  = ~disp_dp_next[idx_next];
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      run_reg       <= 1'b0;
      presc_reg     <= '0;
      idx_reg       <= '0;
      disp_bcd_reg  <= '0;
      disp_dp_reg   <= '0;
      pend_bcd_reg  <= '0;
      pend_dp_reg   <= '0;
      pend_flag_reg <= 1'b0;
      seg_reg       <= SEG_BLANK;
      dp_reg        <= 1'b1;
      an_reg        <= '1;
      frame_reg     <= 1'b0;
    end else begin
      run_reg       <= 1'b1;
      presc_reg     <= presc_next;
      idx_reg       <= idx_next;
      disp_bcd_reg  <= disp_bcd_next;
      disp_dp_reg   <= disp_dp_next;
      pend_bcd_reg  <= pend_bcd_next;
      pend_dp_reg   <= pend_dp_next;
      pend_flag_reg <= pend_flag_next;
      seg_reg       <= seg_next;
      dp_reg        <= dp_next;
      an_reg        <= an_next;
      frame_reg     <= swap;
    end
  end

  assign SEG_o   = seg_reg;
  assign DP_o    = dp_reg;
  assign AN_o    = an_reg;
  assign FRAME_o = frame_reg;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
module tb_bcd_7seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame;

  int checks = 0;
  int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  always #5 clk = ~clk;

  bcd_7seg_scan #(
    .N_DIGITS    (4),
    .REFRESH_DIV (4)
  ) dut (
    .CLK_i   (clk),
    .RST_N_i (rst_n),
    .BCD_i   (bcd),
    .DP_i    (dp_in),
    .LOAD_i  (load),
    .SEG_o   (seg),
    .DP_o    (dp_out),
    .AN_o    (an),
    .FRAME_o (frame)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Runs one full 16-cycle frame starting with the edge that enters the
  // digit-0 slot; LOAD_i is dropped after that first edge.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpm);
    logic [6:0] s [4];
    logic [3:0] an_exp;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int p = 0; p < 4; p++) begin
        tick();
        load = 1'b0;
        an_exp = 4'b0001 << d;
        an_exp = (p == 0) ? 4'hF : ~an_exp;
        chk($sformatf("an d%0d p%0d", d, p), 16'(an), 16'(an_exp));
        chk($sformatf("seg d%0d p%0d", d, p), 16'(seg), 16'(s[d]));
        chk($sformatf("dp d%0d p%0d", d, p), 16'(dp_out), 16'(!dpm[d]));
        chk($sformatf("frame d%0d p%0d", d, p), 16'(frame), 16'(d == 0 && p == 0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bcd   = '0;
    dp_in = '0;
    load  = 1'b0;

    // Reset values.
    repeat (3) tick();
    chk("rst seg", 16'(seg), 16'h7F);
    chk("rst dp", 16'(dp_out), 16'h1);
    chk("rst an", 16'(an), 16'hF);
    chk("rst frame", 16'(frame), 16'h0);
    $display("reset values checked");

    // First edge after release enters the digit-0 slot.
    rst_n = 1'b1;
    tick();
    chk("first frame", 16'(frame), 16'h1);
    chk("first an", 16'(an), 16'hF);
    chk("first seg", 16'(seg), 16'h40);
    chk("first dp", 16'(dp_out), 16'h1);
    $display("first edge after reset checked");

    // Load 1234 mid-frame: goes to pending, old value still shown.
    bcd = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    chk("pend an", 16'(an), 16'hE);
    chk("pend seg", 16'(seg), 16'h40);
    chk("pend frame", 16'(frame), 16'h0);
    repeat (14) tick();
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
    $display("frame 1234 checked");

    // Two loads in one frame: only the later one is ever shown.
    tick();
    chk("ow hold seg", 16'(seg), 16'h19);
    chk("ow hold frame", 16'(frame), 16'h1);
    bcd = 16'h0007; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    bcd = 16'h0042; load = 1'b1;
    tick();
    load = 1'b0;
    chk("ow slot1 an", 16'(an), 16'hF);
    chk("ow slot1 seg", 16'(seg), 16'h30);
    repeat (11) tick();
    check_frame(7'h24, 7'h19, LZ, LZ, 4'b0000);
    $display("overwrite 0007->0042 checked");

    // Load on the swap edge, digit code C blank, DP on digit 2.
    bcd = 16'h9C81; dp_in = 4'b0100; load = 1'b1;
    check_frame(7'h79, 7'h00, 7'h7F, 7'h10, 4'b0100);
    // Pending flag must be clear: stale pending 0042 must not reappear.
    check_frame(7'h79, 7'h00, 7'h7F, 7'h10, 4'b0100);
    $display("swap-edge load and blank code checked");

    // Leading-zero handling on 0050.
    dp_in = 4'b0000;
    tick();
    chk("lz hold seg", 16'(seg), 16'h79);
    bcd = 16'h0050; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (14) tick();
    check_frame(7'h40, 7'h12, LZ, LZ, 4'b0000);
    $display("value 0050 checked");

    // Asynchronous reset during the digit-2 active phase.
    repeat (10) tick();
    chk("pre-rst an", 16'(an), 16'hB);
    chk("pre-rst seg", 16'(seg), 16'(LZ));
    rst_n = 1'b0;
    #1;
    chk("async seg", 16'(seg), 16'h7F);
    chk("async an", 16'(an), 16'hF);
    chk("async dp", 16'(dp_out), 16'h1);
    chk("async frame", 16'(frame), 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart frame", 16'(frame), 16'h1);
    chk("restart an", 16'(an), 16'hF);
    chk("restart seg", 16'(seg), 16'h40);
    tick();
    chk("restart an0", 16'(an), 16'hE);
    repeat (14) tick();
    check_frame(7'h40, LZ, LZ, LZ, 4'b0000);
    $display("mid-frame reset checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Time-multiplexed 7-segment display driver that sits directly downstream of the binary-to-BCD converter in the BinTo7Seg design. It accepts the packed 4-bit-per-digit BCD word, holds it in a double buffer that updates only at frame boundaries, and scans the digits one at a time onto a shared, active-low segment bus with per-digit anode enables. The driver inserts dead time between digits to suppress ghosting.

## Interface
- N_DIGITS, 4, number of digits scanned; BCD_i packs digit k in bits [4k+3:4k], digit 0 = least significant.
- REFRESH_DIV, 50000, clock cycles per digit slot; minimum legal value 2.
- CLK_i  input  1  single clock; all state changes on rising edge.
- RST_N_i  input  1  reset, asynchronous, active-low.
- BCD_i  input  4*N_DIGITS  BCD word to display.
- DP_i  input  N_DIGITS  decimal-point request per digit, 1 = lit.
- LOAD_i  input  1  capture BCD_i/DP_i into pending buffer this cycle.
- SEG_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP_o  output  1  decimal point, active-low.
- AN_o  output  N_DIGITS  digit enables, active-low, at most one low.
- FRAME_o  output  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- Reset values: SEG_o = 7'h7F, DP_o = 1, AN_o = all 1, FRAME_o = 0; prescaler = 0, digit index = 0, display and pending buffers = 0, pending flag = 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps; wrap advances the digit index, which goes 0..N_DIGITS-1, then back to 0.
- Slot start is the cycle in which the prescaler reads 0:
  - AN_o is all 1 (dead time).
  - SEG_o/DP_o present the decode of the new index.
  - FRAME_o = 1 when the index is 0.
- Remaining REFRESH_DIV-1 cycles of the slot: AN_o[index] = 0.
- Buffering: LOAD_i = 1 stores BCD_i/DP_i in the pending buffer and sets the pending flag. Later loads before the swap overwrite the pending buffer.
- Swap: on the edge that enters a digit-0 slot, if the pending flag is set, display buffer <= pending buffer and the flag clears.
- LOAD_i coincident with that edge: BCD_i/DP_i go straight to the display buffer and the flag stays clear. The newest value wins.
- Decode for codes 0..9: standard patterns, e.g. 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, 9 = 7'h10.
- Decode for codes 10..15: blank (7'h7F). DP is still honoured.
- Reset asserted mid-frame: all outputs immediately take reset values; the scan restarts at digit 0 with blank content after deassertion.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- First edge after reset release: prescaler = 0, index = 0, FRAME_o = 1, AN_o all 1. AN_o[0] goes low one cycle later.
- Load-to-visible latency: from 1 cycle (coincident with swap) up to N_DIGITS*REFRESH_DIV cycles.
- Frame period is exactly N_DIGITS*REFRESH_DIV cycles. FRAME_o period is identical.

## Configuration
- LEADING_ZERO_BLANK_EN defined: a digit reads blank (7'h7F, DP still honoured) when it and every more-significant digit in the display buffer are 0. Digit 0 is never blanked.
- LEADING_ZERO_BLANK_EN undefined: every digit is decoded literally, zeros included.

## Structure
- Package bcd_7seg_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK = 7'h7F;
  - segment bit-order constants;
  - the minimum REFRESH_DIV value.
- Sub-module bcd_to_seg: a purely combinational 4-bit-to-7-segment decoder. bcd_7seg_scan instantiates it once on the muxed digit.

## Test plan
- Reset, N_DIGITS=4, REFRESH_DIV=4, LOAD 16'h1234 -> slots digit 0..3 show 7'h19 (4), 7'h30 (3), 7'h24 (2), 7'h79 (1); AN_o sequence 1111/1110 x3, 1111/1101 x3, etc.; FRAME_o every 16 cycles.
- LOAD 16'h0007 mid-frame, then LOAD 16'h0042 before the wrap -> display changes only at the next FRAME_o, showing 0042; 0007 is never shown.
- LOAD asserted on the exact swap edge -> new value shown in that same digit-0 slot; pending flag 0 afterwards.
- BCD digit code 4'hC with DP_i = 4'b0100 -> that slot SEG_o = 7'h7F; digit 2 DP_o = 0.
- With LEADING_ZERO_BLANK_EN, value 16'h0050 -> digits 3..2 blank, digit 1 = 7'h12, digit 0 = 7'h40. Without the macro, digits 3..2 = 7'h40.
- Assert RST_N_i during the digit-2 active phase -> SEG_o = 7'h7F, AN_o = 4'hF immediately, without waiting for a clock edge; after release the scan restarts at digit 0 with FRAME_o on the first edge.
